// File: rtl/i2s_pkg.sv
// Shared definitions for the IIS receive front-end: channel codes, FSM states
// and the default output word width.
package i2s_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RECV
  } rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with a single-cycle rising-edge
// strobe derived from the synchronised level.
module i2s_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic pclk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   q_prev;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      q_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      q_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~q_prev;

endmodule

// File: rtl/i2s_rx_frontend.sv
// I2S (Philips, MSB-first) receiver running entirely in the pclk domain; completed
// words are offered on a valid/ready register with overrun and word counting.
module i2s_rx_frontend
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr_i,
  input  logic                  sck_i,
  input  logic                  ws_i,
  input  logic                  sd_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  chan_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overrun_o,
  output logic [31:0]           word_cnt_o
);

  localparam int unsigned     CNT_W   = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH);

  logic sck_sync_unused, ws_rise_unused, sd_rise_unused;
  logic sck_rise, ws_s, sd_s;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .pclk(pclk), .rst(rst), .d(sck_i), .q(sck_sync_unused), .rise(sck_rise)
  );
  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ws (
    .pclk(pclk), .rst(rst), .d(ws_i), .q(ws_s), .rise(ws_rise_unused)
  );
  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sd (
    .pclk(pclk), .rst(rst), .d(sd_i), .q(sd_s), .rise(sd_rise_unused)
  );

  rx_state_t             state, state_n;
  logic [DATA_WIDTH-1:0] word_q, word_n;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
  logic                  ws_prev, ws_prev_n;
  logic                  done;
  logic [DATA_WIDTH-1:0] done_word;
  logic                  done_chan;
  logic                  load, drop;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      word_q  <= '0;
      bit_cnt <= '0;
      ws_prev <= CH_LEFT;
    end else begin
      state   <= state_n;
      word_q  <= word_n;
      bit_cnt <= bit_cnt_n;
      ws_prev <= ws_n_sel();
    end
  end

  function automatic logic ws_n_sel();
    return ws_prev_n;
  endfunction

  always_comb begin
    state_n   = state;
    word_n    = word_q;
    bit_cnt_n = bit_cnt;
    ws_prev_n = ws_prev;
    done      = 1'b0;
    done_word = word_q;
    done_chan = ws_prev;
    if (!en) begin
      state_n   = IDLE;
      word_n    = '0;
      bit_cnt_n = '0;
      if (sck_rise) ws_prev_n = ws_s;
    end else begin
      case (state)
        IDLE: begin
          word_n    = '0;
          bit_cnt_n = '0;
          if (sck_rise) ws_prev_n = ws_s;
          state_n   = ALIGN;
        end
        ALIGN: begin
          if (sck_rise) begin
            ws_prev_n = ws_s;
            if (ws_s != ws_prev) begin
              state_n   = RECV;
              word_n    = '0;
              bit_cnt_n = '0;
            end
          end
        end
        RECV: begin
          if (sck_rise) begin
            // No bit position matches once bit_cnt has saturated, so overlong slots drop their tail.
            for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
              if (CNT_W'(DATA_WIDTH - 1 - i) == bit_cnt) word_n[i] = sd_s;
            end
            if (ws_s != ws_prev) begin
              done      = 1'b1;
              done_word = word_n;
              done_chan = ws_prev;
              word_n    = '0;
              bit_cnt_n = '0;
              ws_prev_n = ws_s;
            end else if (bit_cnt != CNT_MAX) begin
              bit_cnt_n = bit_cnt + CNT_W'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign load = done && (!valid_o || ready_i);
  assign drop = done && !load;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      data_o     <= '0;
      chan_o     <= CH_LEFT;
      valid_o    <= 1'b0;
      overrun_o  <= 1'b0;
      word_cnt_o <= '0;
    end else begin
      if (load) begin
        data_o     <= done_word;
        chan_o     <= done_chan;
        valid_o    <= 1'b1;
        word_cnt_o <= word_cnt_o + 32'd1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (drop) overrun_o <= 1'b1;
      else if (clr_i) overrun_o <= 1'b0;
    end
  end

endmodule
